// File: rtl/magnitude_stream.sv
// magnitude_stream: streaming two's-complement to unsigned magnitude converter.
// Registered one-deep output stage with valid/ready on both sides, optional
// clamping of the most-negative input, a running peak magnitude and a
// saturating count of most-negative samples.
module magnitude_stream #(
  parameter int IN_WIDTH  = 17,
  parameter bit SATURATE  = 1'b1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IN_WIDTH-2:0]   out_data,
  output logic                  out_sat,
  output logic [IN_WIDTH-2:0]   peak,
  input  logic                  peak_clear,
  output logic [CNT_WIDTH-1:0]  sat_count
);

  localparam int OW = IN_WIDTH - 1;

  logic          sign;
  logic          is_min;
  logic [OW-1:0] neg_mag;
  logic [OW-1:0] mag;
  logic          accept;
  logic          consume;

  // The output register can take a new sample whenever it is empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // Magnitude of the incoming sample; the most-negative value is flagged separately.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sign    = in_data[IN_WIDTH-1];
    is_min  = 1'b0;
    neg_mag = ~in_data[OW-1:0] + OW'(1);
    mag     = in_data[OW-1:0];
    if (sign) begin
      is_min = (in_data[OW-1:0] == '0);
      if (is_min) begin
        // Negating the most-negative value wraps to zero; clamp it when enabled.
        mag = SATURATE ? '1 : '0;
      end else begin
        mag = neg_mag;
      end
    end
  end

  // Output stage: load on accept, empty on consume without accept, hold otherwise.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!n_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mag;
      out_sat   <= is_min;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

  // Peak tracker: a clear with a new sample restarts history at that sample.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      peak <= '0;
    end else if (accept) begin
      if (peak_clear || (mag > peak)) begin
        peak <= mag;
      end
    end else if (peak_clear) begin
      peak <= '0;
    end
  end

  // Saturating count of accepted most-negative samples.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sat_count <= '0;
    end else if (accept && is_min && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_magnitude_stream.sv
// tb_magnitude_stream: three instances (clamp, legacy wrap, 2-bit counter) share
// one input stream and are compared against an arithmetic reference model
// using a queue of pending results.
module tb_magnitude_stream;

  logic        clk;
  logic        n_rst;
  logic        in_valid;
  logic [16:0] in_data;
  logic        out_ready;
  logic        peak_clear;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [15:0] out_data_a, out_data_b, out_data_c;
  logic        out_sat_a, out_sat_b, out_sat_c;
  logic [15:0] peak_a, peak_b, peak_c;
  logic [7:0]  sat_count_a, sat_count_b;
  logic [1:0]  sat_count_c;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] m_sat;
    logic [15:0] m_wrap;
    logic        sat;
  } result_t;

  result_t     pend_q[$];
  logic [15:0] mdl_peak_sat, mdl_peak_wrap;
  int          mdl_cnt8, mdl_cnt2;

  magnitude_stream #(.IN_WIDTH(17), .SATURATE(1'b1), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_sat(out_sat_a), .peak(peak_a),
    .peak_clear(peak_clear), .sat_count(sat_count_a)
  );

  magnitude_stream #(.IN_WIDTH(17), .SATURATE(1'b0), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_sat(out_sat_b), .peak(peak_b),
    .peak_clear(peak_clear), .sat_count(sat_count_b)
  );

  magnitude_stream #(.IN_WIDTH(17), .SATURATE(1'b1), .CNT_WIDTH(2)) dut_c (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_data(out_data_c), .out_sat(out_sat_c), .peak(peak_c),
    .peak_clear(peak_clear), .sat_count(sat_count_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference magnitude from the signed value with ordinary integer arithmetic.
  function automatic logic [15:0] ref_mag(input logic [16:0] d, input bit sat);
    int v;
    int a;
    v = int'($signed(d));
    a = (v < 0) ? -v : v;
    if (a == 65536) return sat ? 16'hFFFF : 16'h0000;
    return a[15:0];
  endfunction

  function automatic bit ref_is_min(input logic [16:0] d);
    return int'($signed(d)) == -65536;
  endfunction

  task automatic model_clear();
    pend_q.delete();
    mdl_peak_sat  = '0;
    mdl_peak_wrap = '0;
    mdl_cnt8      = 0;
    mdl_cnt2      = 0;
  endtask

  task automatic check_stats(input string tag);
    check({tag, " peak_a"}, peak_a, mdl_peak_sat);
    check({tag, " peak_b"}, peak_b, mdl_peak_wrap);
    check({tag, " peak_c"}, peak_c, mdl_peak_sat);
    check({tag, " cnt_a"}, sat_count_a, mdl_cnt8);
    check({tag, " cnt_b"}, sat_count_b, mdl_cnt8);
    check({tag, " cnt_c"}, sat_count_c, mdl_cnt2);
  endtask

  // Reset edge with arbitrary handshake inputs present; all of them must be ignored.
  task automatic apply_reset(input logic v, input logic [16:0] d, input logic ordy, input logic clr);
    n_rst = 1'b0; in_valid = v; in_data = d; out_ready = ordy; peak_clear = clr;
    @(posedge clk); #1;
    model_clear();
    check("rst out_valid_a", out_valid_a, 1'b0);
    check("rst out_valid_b", out_valid_b, 1'b0);
    check("rst out_data_a", out_data_a, 16'h0);
    check("rst out_sat_a", out_sat_a, 1'b0);
    check("rst in_ready_a", in_ready_a, 1'b1);
    check_stats("rst");
    n_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; peak_clear = 1'b0;
  endtask

  // One clock cycle: drive, check the pre-edge view, advance model, check post-edge stats.
  task automatic cycle(input logic v, input logic [16:0] d, input logic ordy, input logic clr);
    bit    exp_valid, exp_ready, acc, con, mn;
    result_t r;
    in_valid = v; in_data = d; out_ready = ordy; peak_clear = clr;
    @(negedge clk);
    exp_valid = (pend_q.size() != 0);
    exp_ready = !exp_valid || ordy;
    check("in_ready_a", in_ready_a, exp_ready);
    check("in_ready_b", in_ready_b, exp_ready);
    check("in_ready_c", in_ready_c, exp_ready);
    check("out_valid_a", out_valid_a, exp_valid);
    check("out_valid_b", out_valid_b, exp_valid);
    check("out_valid_c", out_valid_c, exp_valid);
    if (exp_valid) begin
      check("out_data_a", out_data_a, pend_q[0].m_sat);
      check("out_data_b", out_data_b, pend_q[0].m_wrap);
      check("out_data_c", out_data_c, pend_q[0].m_sat);
      check("out_sat_a", out_sat_a, pend_q[0].sat);
      check("out_sat_b", out_sat_b, pend_q[0].sat);
    end
    acc = v && exp_ready;
    con = exp_valid && ordy;
    if (con) void'(pend_q.pop_front());
    mn = ref_is_min(d);
    if (acc) begin
      r.m_sat  = ref_mag(d, 1'b1);
      r.m_wrap = ref_mag(d, 1'b0);
      r.sat    = mn;
      pend_q.push_back(r);
      if (clr) begin
        mdl_peak_sat  = r.m_sat;
        mdl_peak_wrap = r.m_wrap;
      end else begin
        if (r.m_sat > mdl_peak_sat) mdl_peak_sat = r.m_sat;
        if (r.m_wrap > mdl_peak_wrap) mdl_peak_wrap = r.m_wrap;
      end
      if (mn) begin
        mdl_cnt8 = (mdl_cnt8 < 255) ? mdl_cnt8 + 1 : 255;
        mdl_cnt2 = (mdl_cnt2 < 3) ? mdl_cnt2 + 1 : 3;
      end
    end else if (clr) begin
      mdl_peak_sat  = '0;
      mdl_peak_wrap = '0;
    end
    @(posedge clk); #1;
    check_stats("cyc");
  endtask

  initial begin
    logic [15:0] peak_b_before;
    logic [16:0] rd;
    n_rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; peak_clear = 1'b0;
    model_clear();
    apply_reset(1'b1, 17'h0ABCD, 1'b1, 1'b1);

    // Single samples, one cycle latency.
    cycle(1'b1, 17'h0ABCD, 1'b1, 1'b0);
    check("lat abcd valid", out_valid_a, 1'b1);
    check("lat abcd data", out_data_a, 16'hABCD);
    check("lat abcd sat", out_sat_a, 1'b0);
    cycle(1'b1, 17'h1FFFF, 1'b1, 1'b0);
    check("neg one data", out_data_a, 16'h0001);
    cycle(1'b1, 17'h00000, 1'b1, 1'b0);
    check("zero data", out_data_a, 16'h0000);
    cycle(1'b0, 17'h00000, 1'b1, 1'b0);

    // Most-negative input in both modes.
    peak_b_before = peak_b;
    cycle(1'b1, 17'h10000, 1'b1, 1'b0);
    check("min sat data", out_data_a, 16'hFFFF);
    check("min sat flag", out_sat_a, 1'b1);
    check("min wrap data", out_data_b, 16'h0000);
    check("min wrap flag", out_sat_b, 1'b1);
    check("min wrap peak", peak_b, peak_b_before);
    check("min cnt", sat_count_a, 8'd1);
    cycle(1'b0, 17'h00000, 1'b1, 1'b0);

    // Backpressure: one held result, then drain in order.
    cycle(1'b1, 17'h00005, 1'b0, 1'b0);
    cycle(1'b1, 17'h1FFFE, 1'b0, 1'b0);
    check("bp hold data", out_data_a, 16'h0005);
    cycle(1'b1, 17'h1FFFE, 1'b0, 1'b0);
    cycle(1'b1, 17'h1FFFE, 1'b1, 1'b0);
    cycle(1'b1, 17'h00010, 1'b1, 1'b0);
    cycle(1'b0, 17'h00000, 1'b1, 1'b0);
    cycle(1'b0, 17'h00000, 1'b1, 1'b0);

    // Peak tracking with clear variants.
    cycle(1'b1, 17'h00003, 1'b1, 1'b1);
    cycle(1'b1, 17'h1FF00, 1'b1, 1'b0);
    cycle(1'b1, 17'h00050, 1'b1, 1'b0);
    check("peak max", peak_a, 16'h0100);
    cycle(1'b1, 17'h00007, 1'b1, 1'b1);
    check("peak clr acc", peak_a, 16'h0007);
    cycle(1'b0, 17'h00000, 1'b1, 1'b1);
    check("peak clr only", peak_a, 16'h0000);

    // Counter saturation on the 2-bit instance.
    apply_reset(1'b0, 17'h00000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 17'h10000, 1'b1, 1'b0);
      check("cnt2 seq", sat_count_c, (i < 3) ? i + 1 : 3);
    end
    cycle(1'b0, 17'h00000, 1'b1, 1'b0);

    // Randomized traffic with extreme values mixed in.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 6))
        0:       rd = 17'h10000;
        1:       rd = 17'h1FFFF;
        2:       rd = 17'h00000;
        3:       rd = 17'h0FFFF;
        4:       rd = 17'h10001;
        default: rd = 17'($urandom);
      endcase
      cycle(1'($urandom_range(0, 3) != 0), rd, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
    end

    // Reset while a result is held: it must never appear.
    cycle(1'b1, 17'h00123, 1'b0, 1'b0);
    check("pre-rst valid", out_valid_a, 1'b1);
    apply_reset(1'b1, 17'h10000, 1'b0, 1'b0);
    cycle(1'b0, 17'h00000, 1'b1, 1'b0);
    cycle(1'b0, 17'h00000, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/magnitude_stream.md
Name: magnitude_stream

Overview:
Streaming, parametrised successor to the single-cycle two's-complement magnitude converter in the filter datapath. It takes signed samples over a valid/ready handshake and returns their unsigned magnitude through a registered output stage. Optional saturation handles the most-negative input, and the block tracks a running peak magnitude and a saturation event count. It sits between the FIR accumulator output and the result register/AHB read path.

Parameters:
IN_WIDTH, 17, signed input width in bits; minimum 2.
SATURATE, 1, 1 = most-negative input clamps to all-ones; 0 = legacy wrap (output 0).
CNT_WIDTH, 8, width of the saturation event counter.

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  synchronous active-low reset.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample this cycle.
in_data  in  IN_WIDTH  signed two's-complement sample.
out_valid  out  1  out_data holds a valid result.
out_ready  in  1  downstream accepts out_data this cycle.
out_data  out  IN_WIDTH-1  unsigned magnitude.
out_sat  out  1  qualifies out_data: the result was the most-negative input (clamped or wrapped).
peak  out  IN_WIDTH-1  largest magnitude accepted since reset or the last clear.
peak_clear  in  1  synchronous clear of peak.
sat_count  out  CNT_WIDTH  number of most-negative inputs accepted; saturates at all-ones.

Behaviour:
- Reset: the clock edge with n_rst=0 forces out_valid=0, out_data=0, out_sat=0, peak=0 and sat_count=0. This overrides any handshake or clear in the same cycle. A sample in flight is discarded.
- Input handshake: a sample is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational and gives one-deep pipeline-register behaviour, with no bubble under continuous flow.
- Output handshake: a result is consumed when out_valid && out_ready.
- out_data and out_sat are held stable while out_valid && !out_ready.
- Latency: exactly 1 cycle from input acceptance to out_valid.
- Register update rules:
  - Accept (with or without a simultaneous consume): out_valid <= 1 and the new result is loaded.
  - Consume with no accept: out_valid <= 0.
- Magnitude rule, with m = the IN_WIDTH-1 output bits:
  - in_data[MSB]=0: m = in_data[IN_WIDTH-2:0].
  - in_data[MSB]=1 and the value is not most-negative: m = (~in_data + 1) truncated to IN_WIDTH-1 bits.
  - Most-negative (MSB=1, all other bits 0):
    - SATURATE=1: m = all-ones.
    - SATURATE=0: m = 0, the legacy result.
    - out_sat = 1 in both modes.
  - Full-range behaviour is required for IN_WIDTH = 2 through 32.
- Peak tracker (updated only on acceptance):
  - Accept with no clear: peak <= max(peak, m).
  - peak_clear with no accept: peak <= 0.
  - peak_clear and accept in the same cycle: peak <= m. The new sample is included and older history is dropped.
  - A wrapped most-negative sample (SATURATE=0, m=0) does not raise peak.
- Saturation counter:
  - Increments on each accepted most-negative sample.
  - Holds at 2^CNT_WIDTH-1 and never wraps.
  - Cleared only by reset.
- No other state; no FSM beyond the valid bit. All outputs are registered except in_ready.

Test Plan:
- Reset then single samples (IN_WIDTH=17, SATURATE=1), out_ready=1: in 0x0ABCD -> out 0xABCD; in 0x1FFFF -> 0x0001; in 0x00000 -> 0x0000. Each result appears 1 cycle after acceptance with out_sat=0.
- Most-negative input 0x10000: with SATURATE=1 -> out 0xFFFF, out_sat=1, sat_count increments by 1. With SATURATE=0 -> out 0x0000, out_sat=1, and peak is unchanged.
- Backpressure: stream 0x00005, 0x1FFFE, 0x00010 with out_ready=0 for 3 cycles. Required: in_ready=0 after the first accept, and out_data held at 0x0005. Release -> outputs 0x0005, 0x0002, 0x0010 in order, none lost or duplicated. Continuous flow with out_ready=1 -> one result per cycle.
- Peak tracking: inputs 0x00003, 0x1FF00 (mag 0x0100), 0x00050 -> peak=0x0100. Then peak_clear together with input 0x00007 -> peak=0x0007. Then peak_clear alone -> peak=0x0000.
- Counter saturation (CNT_WIDTH=2): 5 accepted 0x10000 samples -> sat_count sequence 1, 2, 3, 3, 3.
- Reset mid-stream: n_rst=0 while out_valid=1 and out_ready=0 -> next edge gives out_valid=0, peak=0, sat_count=0, in_ready=1. The held sample is never emitted.
